// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller: host load, run, pipeline drain, done for the 5-stage CPU.
// Optional cycle-limit stop built when CPU_RUN_CYCLE_LIMIT_EN is defined.
module cpu_run_ctrl #(
  parameter int         CNT_W        = 32,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [5:0] HALT_OPCODE  = 6'h3F
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [31:0]      if_instruction,
  input  logic             host_wen,
  input  logic             host_ren,
  output logic             cpu_enable,
  output logic             if_squash,
  output logic             ext_wen,
  output logic             ext_ren,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            armed;
  logic [CNT_W-1:0] count_inc;
  logic            halt_hit;
  logic            limit_hit;
  logic            unused_inputs;

  always_comb begin
    count_inc = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    halt_hit  = (if_instruction[31:26] == HALT_OPCODE);
`ifdef CPU_RUN_CYCLE_LIMIT_EN
    limit_hit = (max_cycles != '0) && (count_inc == max_cycles);
`else
    limit_hit = 1'b0;
`endif
  end

`ifdef CPU_RUN_CYCLE_LIMIT_EN
  assign unused_inputs = ^if_instruction[25:0];
`else
  assign unused_inputs = ^{if_instruction[25:0], max_cycles};
`endif

  // Host traffic is dropped, not queued, while the pipeline owns the memories.
  assign ext_wen = host_wen & ~busy;
  assign ext_ren = host_ren & ~busy;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      armed       <= 1'b0;
      cpu_enable  <= 1'b0;
      if_squash   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stop_cause  <= CAUSE_NONE;
      cycle_count <= '0;
    end else begin
      // armed blocks a start sampled on the first edge after reset release
      armed <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && armed) begin
            state       <= S_RUN;
            cpu_enable  <= 1'b1;
            if_squash   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            stop_cause  <= CAUSE_NONE;
            cycle_count <= '0;
          end
        end

        S_RUN: begin
          cycle_count <= count_inc;
          if (abort || ((halt_hit || limit_hit) && DRAIN_CYCLES == 0)) begin
            state      <= S_DONE;
            cpu_enable <= 1'b0;
            if_squash  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            stop_cause <= abort ? CAUSE_ABORT : (halt_hit ? CAUSE_HALT : CAUSE_LIMIT);
          end else if (halt_hit || limit_hit) begin
            state      <= S_DRAIN;
            if_squash  <= 1'b1;
            drain_cnt  <= DRAIN_LOAD;
            stop_cause <= halt_hit ? CAUSE_HALT : CAUSE_LIMIT;
          end
        end

        S_DRAIN: begin
          cycle_count <= count_inc;
          if (abort || drain_cnt == '0) begin
            state      <= S_DONE;
            cpu_enable <= 1'b0;
            if_squash  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            if (abort) stop_cause <= CAUSE_ABORT;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        abort;
  logic [31:0] max_cycles;
  logic [31:0] if_instruction;
  logic        host_wen;
  logic        host_ren;
  logic        cpu_enable;
  logic        if_squash;
  logic        ext_wen;
  logic        ext_ren;
  logic        busy;
  logic        done;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;
  int sq;

  cpu_run_ctrl dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .start          (start),
    .abort          (abort),
    .max_cycles     (max_cycles),
    .if_instruction (if_instruction),
    .host_wen       (host_wen),
    .host_ren       (host_ren),
    .cpu_enable     (cpu_enable),
    .if_squash      (if_squash),
    .ext_wen        (ext_wen),
    .ext_ren        (ext_ren),
    .busy           (busy),
    .done           (done),
    .stop_cause     (stop_cause),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; abort = 1'b0; max_cycles = 32'd0;
    if_instruction = NOP_W; host_wen = 1'b0; host_ren = 1'b0;
    tick(); tick();

    chk("rst_enable", {31'd0, cpu_enable}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_squash", {31'd0, if_squash}, 32'd0);
    chk("rst_cause",  {30'd0, stop_cause}, 32'd0);
    chk("rst_count",  cycle_count, 32'd0);

    // start on the reset-release cycle must be ignored
    arst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_at_release", {31'd0, busy}, 32'd0);

    host_wen = 1'b1; host_ren = 1'b1; #1;
    chk("idle_ext_wen", {31'd0, ext_wen}, 32'd1);
    chk("idle_ext_ren", {31'd0, ext_ren}, 32'd1);
    host_wen = 1'b0; host_ren = 1'b0;

    // halt at RUN cycle 7, unlimited
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_enable", {31'd0, cpu_enable}, 32'd1);
    chk("t1_count0", cycle_count, 32'd0);
    repeat (6) tick();
    chk("t1_count6", cycle_count, 32'd6);
    if_instruction = HALT_W; tick(); if_instruction = NOP_W;
    chk("t1_drain_squash", {31'd0, if_squash}, 32'd1);
    chk("t1_drain_cause", {30'd0, stop_cause}, 32'd1);
    sq = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      sq += int'(if_squash);
      tick();
    end
    chk("t1_squash_cycles", sq, 32'd4);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_enable_off", {31'd0, cpu_enable}, 32'd0);
    chk("t1_cause", {30'd0, stop_cause}, 32'd1);
    chk("t1_count", cycle_count, 32'd11);
    host_wen = 1'b1; #1;
    chk("done_ext_wen", {31'd0, ext_wen}, 32'd1);
    host_wen = 1'b0;

    // cycle limit M=5
    max_cycles = 32'd5;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_cause_cleared", {30'd0, stop_cause}, 32'd0);
    repeat (9) tick();
`ifdef CPU_RUN_CYCLE_LIMIT_EN
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_cause", {30'd0, stop_cause}, 32'd2);
    chk("t2_count", cycle_count, 32'd9);
`else
    repeat (11) tick();
    chk("t2_busy20", {31'd0, busy}, 32'd1);
    chk("t2_cause0", {30'd0, stop_cause}, 32'd0);
    chk("t2_count20", cycle_count, 32'd20);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t2_abort_cause", {30'd0, stop_cause}, 32'd3);
    chk("t2_abort_count", cycle_count, 32'd21);
`endif
    max_cycles = 32'd0;

    // abort at RUN cycle 3, then abort in DONE ignored
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_enable", {31'd0, cpu_enable}, 32'd0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_cause", {30'd0, stop_cause}, 32'd3);
    chk("t3_count", cycle_count, 32'd3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_in_done", cycle_count, 32'd3);

    // abort during DRAIN
    start = 1'b1; tick(); start = 1'b0;
    if_instruction = HALT_W; tick(); if_instruction = NOP_W;
    tick();
    chk("t3b_in_drain", {31'd0, if_squash}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3b_done", {31'd0, done}, 32'd1);
    chk("t3b_cause", {30'd0, stop_cause}, 32'd3);
    chk("t3b_count", cycle_count, 32'd3);

    // halt and limit together: halt wins
    max_cycles = 32'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    if_instruction = HALT_W; tick(); if_instruction = NOP_W;
    chk("t4_cause_halt", {30'd0, stop_cause}, 32'd1);
    repeat (4) tick();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_count", cycle_count, 32'd6);
    max_cycles = 32'd0;

    // abort and halt together: abort wins
    start = 1'b1; tick(); start = 1'b0;
    if_instruction = HALT_W; abort = 1'b1; tick();
    if_instruction = NOP_W; abort = 1'b0;
    chk("t4b_done", {31'd0, done}, 32'd1);
    chk("t4b_cause", {30'd0, stop_cause}, 32'd3);
    chk("t4b_count", cycle_count, 32'd1);

    // host gating and extra start while running
    start = 1'b1; tick(); start = 1'b0;
    host_wen = 1'b1; host_ren = 1'b1; #1;
    chk("run_ext_wen", {31'd0, ext_wen}, 32'd0);
    chk("run_ext_ren", {31'd0, ext_ren}, 32'd0);
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_ignored", cycle_count, 32'd3);
    chk("t5_busy", {31'd0, busy}, 32'd1);

    // async reset during DRAIN
    if_instruction = HALT_W; tick(); if_instruction = NOP_W;
    tick();
    chk("t6_in_drain", {31'd0, if_squash}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_rst_enable", {31'd0, cpu_enable}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_squash", {31'd0, if_squash}, 32'd0);
    chk("t6_rst_count", cycle_count, 32'd0);
    chk("t6_rst_ext_wen", {31'd0, ext_wen}, 32'd1);
    arst_n = 1'b1;
    host_wen = 1'b0; host_ren = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_restart_count0", cycle_count, 32'd0);
    chk("t6_restart_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t6_restart_count1", cycle_count, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_final_done", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
